alu_shift_left_seq: RTL and testbench
=====================================

# alu_shift_left_seq

Sequential left-shift unit for the Mini Project ALU. It is the opposite-direction companion of the ALU's right-shift path. It accepts a narrow operand and a shift amount on a one-cycle start strobe, zero-extends the operand, and shifts it left one bit per clock. When it finishes, it presents the widened result, a sticky carry-out flag and a one-cycle done pulse to the ALU result mux.

## Interface
Parameters:
- IN_W, default 3: operand width.
- OUT_W, default 5: result width. Must be greater than or equal to IN_W.
- AMT_W, default 3: shift-amount width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- a  input  IN_W  operand; captured when start is accepted.
- shamt  input  AMT_W  shift amount (0 to 2^AMT_W-1); captured with a.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid.
- a_shiftl  output  OUT_W  registered result; holds its value until the next done.
- carry  output  1  registered; 1 if any 1 bit was shifted out of the MSB.

## Operation
- FSM states are IDLE, SHIFT and DONE. Internal state is a working register `work` (OUT_W bits), a count `cnt` (AMT_W bits) and a sticky flag `cy`.
- IDLE with start=1:
  - Load `work` with {zeros, a}, load `cnt` with shamt, clear `cy`.
  - If shamt=0, go to DONE; otherwise go to SHIFT.
- IDLE with start=0: stay in IDLE.
- SHIFT, on each cycle:
  - `work` <= `work` << 1, with a 0 shifted into the LSB.
  - `cy` <= `cy` OR `work`[OUT_W-1].
  - `cnt` <= `cnt` - 1.
  - When `cnt`=1 on entry to the cycle, this is the last shift; go to DONE.
- DONE: assert done for exactly one cycle, then go to IDLE.
- a_shiftl and carry are loaded on the edge that enters DONE. They do not change at any other time, except on reset.
- If shamt >= OUT_W, the result is all zeros and carry = OR of the bits of a. The block still spends shamt shift cycles; there is no early exit.
- Arithmetic is logical only: no sign extension and no rotation. Bits above OUT_W are discarded.
- start while busy=1 (SHIFT or DONE) is ignored. It is not queued, and the operands in flight are unaffected.
- Changes on a or shamt after acceptance have no effect.

## Timing
- Reset: rst=1 at a rising edge forces IDLE, busy=0, done=0, a_shiftl=0, carry=0, and clears the internal registers. This also applies mid-SHIFT or in DONE. An aborted operation produces no done pulse.
- Reset has priority over start in the same cycle.
- Start is accepted at edge T, meaning it is sampled high in IDLE during the cycle ending at T.
  - busy is high from cycle T+1 through the done cycle, inclusive.
  - done is high in cycle T+1+shamt.
  - a_shiftl and carry are valid from cycle T+1+shamt onward.
- Throughput: the next start is accepted at the earliest in the cycle after done, i.e. one accepted operation per shamt+2 cycles.
- busy and done are decoded directly from the state register, with no combinational path from inputs.

## Test plan
- Reset the block, then apply a=3'b101, shamt=2, start for one cycle -> done in cycle T+3, a_shiftl=5'b10100, carry=0, busy high for exactly 3 cycles.
- a=3'b111, shamt=3 -> done at T+4, a_shiftl=5'b11000, carry=1.
- a=3'b110, shamt=0 -> done at T+1, a_shiftl=5'b00110, carry=0, busy high for 1 cycle.
- a=3'b001, shamt=7 -> done at T+8, a_shiftl=5'b00000, carry=1. Also check that the previous a_shiftl is held until that done.
- a=3'b011, shamt=4, start; re-assert start with a=3'b111 at T+2 -> the second start is ignored, done at T+5, a_shiftl=5'b10000, carry=1, and no second done pulse.
- a=3'b101, shamt=5, start; assert rst at T+3 -> IDLE, all outputs 0 on the next edge, and no done pulse. A fresh start then operates normally.

Source files
------------

// File: rtl/alu_shift_left_seq_if.sv
// Operand/result bundle of the sequential left-shift unit.
// The ALU side drives start/a/shamt; the shift unit returns status and result.
interface alu_shift_left_seq_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 5,
    parameter int AMT_W = 3
) ();
    logic             start;
    logic [IN_W-1:0]  a;
    logic [AMT_W-1:0] shamt;
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] a_shiftl;
    logic             carry;

    modport master (
        output start, a, shamt,
        input  busy, done, a_shiftl, carry
    );

    modport slave (
        input  start, a, shamt,
        output busy, done, a_shiftl, carry
    );
endinterface

// File: rtl/alu_shift_left_seq.sv
// Sequential logical left shifter: zero-extends a, shifts one bit per clock,
// and reports the widened result plus a sticky carry-out with a one-cycle done.
module alu_shift_left_seq #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 5,
    parameter int AMT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_shift_left_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [OUT_W-1:0] work_reg;
    logic [AMT_W-1:0] cnt_reg;
    logic             cy_reg;
    logic [OUT_W-1:0] a_shiftl_reg;
    logic             carry_reg;

    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] work_next;
    logic             cy_next;

    // Zero-extend the operand bit by bit so OUT_W == IN_W needs no special case.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_ext
            if (gi < IN_W) begin : g_bit
                assign a_ext[gi] = bus.a[gi];
            end else begin : g_zero
                assign a_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign work_next = {work_reg[OUT_W-2:0], 1'b0};
    assign cy_next   = cy_reg | work_reg[OUT_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            work_reg     <= '0;
            cnt_reg      <= '0;
            cy_reg       <= 1'b0;
            a_shiftl_reg <= '0;
            carry_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        work_reg <= a_ext;
                        cnt_reg  <= bus.shamt;
                        cy_reg   <= 1'b0;
                        if (bus.shamt == '0) begin
                            // Zero shift: result is the extended operand, no carry.
                            state_reg    <= DONE;
                            a_shiftl_reg <= a_ext;
                            carry_reg    <= 1'b0;
                        end else begin
                            state_reg <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_reg <= work_next;
                    cy_reg   <= cy_next;
                    cnt_reg  <= cnt_reg - AMT_W'(1);
                    if (cnt_reg == AMT_W'(1)) begin
                        state_reg    <= DONE;
                        a_shiftl_reg <= work_next;
                        carry_reg    <= cy_next;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Status comes straight from the state register: no input-to-output path.
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = (state_reg == DONE);
    assign bus.a_shiftl = a_shiftl_reg;
    assign bus.carry    = carry_reg;
endmodule

// File: tb/tb_alu_shift_left_seq.sv
// Bench for alu_shift_left_seq: directed vector table, start/reset corner
// sequences and random operations checked against an arithmetic shift model.
module tb_alu_shift_left_seq;
    localparam int IN_W  = 3;
    localparam int OUT_W = 5;
    localparam int AMT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_shift_left_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W), .AMT_W(AMT_W)) bus ();

    alu_shift_left_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .AMT_W(AMT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]  a;
        logic [AMT_W-1:0] shamt;
        logic [OUT_W-1:0] res;
        logic             cy;
        int               restart;
    } vec_t;

    int passed = 0;
    int total  = 0;
    logic [OUT_W-1:0] prev_res = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: shift in wide arithmetic, keep the low OUT_W bits, carry is
    // whether anything landed above them.
    function automatic void model(input logic [IN_W-1:0] a, input logic [AMT_W-1:0] sh,
                                  output logic [OUT_W-1:0] r, output logic c);
        logic [63:0] full;
        full = 64'(a) << sh;
        r = full[OUT_W-1:0];
        c = |(full >> OUT_W);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge with the DUT idle; returns #1 after the
    // edge following the post-done cycle check.
    task automatic run_op(input string name, input logic [IN_W-1:0] a, input logic [AMT_W-1:0] sh,
                          input logic [OUT_W-1:0] exp_res, input logic exp_cy, input int restart);
        int lat;
        int bcnt;
        int held_err;
        lat = -1;
        bcnt = 0;
        held_err = 0;
        bus.start = 1'b1;
        bus.a     = a;
        bus.shamt = sh;
        tick();
        bus.start = 1'b0;
        bus.a     = IN_W'($urandom);
        bus.shamt = AMT_W'($urandom);
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.a_shiftl !== prev_res) held_err++;
            if (restart != 0 && k == restart) begin
                bus.start = 1'b1;
                bus.a     = '1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        $display("op %s: a=%b shamt=%0d -> a_shiftl=%b carry=%b latency=%0d busy=%0d",
                 name, a, sh, bus.a_shiftl, bus.carry, lat, bcnt);
        check({name, " latency"}, 64'(lat), 64'(int'(sh) + 1));
        check({name, " busy cycles"}, 64'(bcnt), 64'(int'(sh) + 1));
        check({name, " a_shiftl"}, 64'(bus.a_shiftl), 64'(exp_res));
        check({name, " carry"}, 64'(bus.carry), 64'(exp_cy));
        check({name, " held before done"}, 64'(held_err), 64'd0);
        tick();
        check({name, " done/busy after"}, {62'd0, bus.done, bus.busy}, 64'd0);
        check({name, " result still held"}, 64'(bus.a_shiftl), 64'(exp_res));
        prev_res = exp_res;
    endtask

    vec_t vecs[5];

    initial begin
        logic [OUT_W-1:0] r;
        logic             c;
        logic             saw_done;
        logic [IN_W-1:0]  ra;
        logic [AMT_W-1:0] rs;

        vecs[0] = '{3'b101, 3'd2, 5'b10100, 1'b0, 0};
        vecs[1] = '{3'b111, 3'd3, 5'b11000, 1'b1, 0};
        vecs[2] = '{3'b110, 3'd0, 5'b00110, 1'b0, 0};
        vecs[3] = '{3'b001, 3'd7, 5'b00000, 1'b1, 0};
        vecs[4] = '{3'b011, 3'd4, 5'b10000, 1'b1, 2};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.shamt = '0;
        rst = 1'b1;
        tick();
        tick();
        check("reset outputs", {59'd0, bus.busy, bus.done, bus.carry, 2'd0} | 64'(bus.a_shiftl), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].shamt, vecs[i].res, vecs[i].cy, vecs[i].restart);

        // Reset mid-shift: aborted op must not pulse done and outputs clear.
        saw_done = 1'b0;
        bus.start = 1'b1;
        bus.a     = 3'b101;
        bus.shamt = 3'd5;
        tick();
        bus.start = 1'b0;
        saw_done |= bus.done;
        tick();
        saw_done |= bus.done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("op abort: busy=%b done=%b a_shiftl=%b carry=%b", bus.busy, bus.done, bus.a_shiftl, bus.carry);
        check("abort outputs cleared", {59'd0, bus.busy, bus.done, bus.carry, 2'd0} | 64'(bus.a_shiftl), 64'd0);
        for (int k = 0; k < 8; k++) begin
            saw_done |= bus.done;
            tick();
        end
        check("abort no done", 64'(saw_done), 64'd0);
        prev_res = '0;
        run_op("after abort", 3'b101, 3'd2, 5'b10100, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            ra = IN_W'($urandom);
            rs = AMT_W'($urandom_range(0, (1 << AMT_W) - 1));
            model(ra, rs, r, c);
            run_op($sformatf("rand%0d", i), ra, rs, r, c, (i % 4 == 1) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
